// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared constants, slot encoding and BCD helpers for score_counter and its
// bcd_digit_counter sub-module.
//   BCD_W             width of one BCD digit
//   SCORE_MAX_ONES/TENS  digit values at which the score saturates (99)
//   ANODE_SLOTn       active-low one-hot anode pattern for scan slot n
//   ANODE_BLANK       all anodes off
// ---------------------------------------------------------------------------
package score_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_DIGIT_MAX  = 4'd9;
  localparam logic [BCD_W-1:0] SCORE_MAX_ONES = 4'd9;
  localparam logic [BCD_W-1:0] SCORE_MAX_TENS = 4'd9;

  localparam logic [7:0] ANODE_SLOT0 = 8'b1111_1110;
  localparam logic [7:0] ANODE_SLOT1 = 8'b1111_1101;
  localparam logic [7:0] ANODE_SLOT2 = 8'b1111_1011;
  localparam logic [7:0] ANODE_SLOT3 = 8'b1111_0111;
  localparam logic [7:0] ANODE_BLANK = 8'hFF;

  // Scan slots; the high-score slots are only visited in the high-score build.
  typedef enum logic [1:0] {
    SLOT_ONES      = 2'd0,
    SLOT_TENS      = 2'd1,
    SLOT_HIGH_ONES = 2'd2,
    SLOT_HIGH_TENS = 2'd3
  } slot_e;

  // Two-digit BCD value plus one, {tens, ones}. Caller guarantees value < 99.
  function automatic logic [2*BCD_W-1:0] bcd2_inc(input logic [2*BCD_W-1:0] v);
    logic [2*BCD_W-1:0] r;
    if (v[BCD_W-1:0] == BCD_DIGIT_MAX) begin
      r = {v[2*BCD_W-1:BCD_W] + 4'd1, 4'd0};
    end else begin
      r = {v[2*BCD_W-1:BCD_W], v[BCD_W-1:0] + 4'd1};
    end
    return r;
  endfunction

  // Anode pattern shown while a given slot is active.
  function automatic logic [7:0] slot_anode(input slot_e s);
    logic [7:0] a;
    case (s)
      SLOT_ONES:      a = ANODE_SLOT0;
      SLOT_TENS:      a = ANODE_SLOT1;
      SLOT_HIGH_ONES: a = ANODE_SLOT2;
      SLOT_HIGH_TENS: a = ANODE_SLOT3;
      default:        a = ANODE_BLANK;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit (0..9) with synchronous clear, parallel load and increment.
// Priority: clear > load > inc > hold. Carry pulses combinationally on the
// increment that wraps 9 -> 0, for chaining into the next digit.
//   clk, rst_n   clock, asynchronous active-low reset (digit -> 0)
//   clear        synchronous clear to 0
//   load         load load_val (used when the digit acts as a plain register)
//   load_val     value to load
//   inc          increment by one
//   digit        registered digit value
//   carry        wrap-around carry out
// ---------------------------------------------------------------------------
module bcd_digit_counter
  import score_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  logic [BCD_W-1:0] digit_r;
  logic [BCD_W-1:0] digit_next_s;

  // Next-digit selection by priority.
  always_comb begin
    digit_next_s = digit_r;
    if (clear) begin
      digit_next_s = 4'd0;
    end else if (load) begin
      digit_next_s = load_val;
    end else if (inc) begin
      if (digit_r == BCD_DIGIT_MAX) begin
        digit_next_s = 4'd0;
      end else begin
        digit_next_s = digit_r + 4'd1;
      end
    end else begin
      digit_next_s = digit_r;
    end
  end

  // Digit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r <= 4'd0;
    end else begin
      digit_r <= digit_next_s;
    end
  end

  assign carry = inc & ~clear & ~load & (digit_r == BCD_DIGIT_MAX);
  assign digit = digit_r;

endmodule

// File: rtl/score_counter.sv
// ---------------------------------------------------------------------------
// score_counter
// Two-digit saturating BCD score keeper (0..99) with a time-multiplexed
// seven-segment scan output.
// Optional feature macro: SCORE_COUNTER_HIGH_SCORE_EN -- adds a high-score
// register (survives clear, cleared only by reset) and two extra scan slots.
//   SCAN_DIV               clock cycles per scan slot (>= 2)
//   score_counter_clk      system clock
//   score_counter_rst_n    asynchronous active-low reset
//   score_counter_eat      food-eaten level; each rising edge counts once
//   score_counter_clear    synchronous new-game clear (level)
//   score_counter_ones     score units digit (BCD)
//   score_counter_tens     score tens digit (BCD)
//   score_counter_max      high while score is 99
//   score_counter_digit    digit value for the current scan slot
//   score_counter_anode    active-low one-hot anode vector for that slot
// ---------------------------------------------------------------------------
module score_counter
  import score_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic             score_counter_clk,
  input  logic             score_counter_rst_n,
  input  logic             score_counter_eat,
  input  logic             score_counter_clear,
  output logic [BCD_W-1:0] score_counter_ones,
  output logic [BCD_W-1:0] score_counter_tens,
  output logic             score_counter_max,
  output logic [BCD_W-1:0] score_counter_digit,
  output logic [7:0]       score_counter_anode
);

  localparam int                PRESC_W    = $clog2(SCAN_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  localparam slot_e LAST_SLOT = SLOT_HIGH_TENS;
`else
  localparam slot_e LAST_SLOT = SLOT_TENS;
`endif

  logic               eat_q_r;
  logic               inc_s;
  logic               at_max_s;
  logic               inc_eff_s;
  logic               ones_carry_s;
  logic               tens_carry_unused_s;
  logic [BCD_W-1:0]   ones_s;
  logic [BCD_W-1:0]   tens_s;
  logic [2*BCD_W-1:0] score_s;
  logic [2*BCD_W-1:0] score_inc_s;
  logic [2*BCD_W-1:0] score_next_s;
  logic               max_r;
  logic [BCD_W-1:0]   high_ones_s;
  logic [BCD_W-1:0]   high_tens_s;

  logic [PRESC_W-1:0] presc_r;
  logic               slot_tc_s;
  slot_e              slot_r;
  slot_e              next_slot_s;
  logic [BCD_W-1:0]   digit_sel_s;
  logic [BCD_W-1:0]   digit_r;
  logic [7:0]         anode_r;

  // Eat edge detector; keeps sampling during clear, so a coincident edge is lost.
  always_ff @(posedge score_counter_clk or negedge score_counter_rst_n) begin
    if (!score_counter_rst_n) begin
      eat_q_r <= 1'b0;
    end else begin
      eat_q_r <= score_counter_eat;
    end
  end

  assign inc_s     = score_counter_eat & ~eat_q_r;
  assign at_max_s  = (tens_s == SCORE_MAX_TENS) && (ones_s == SCORE_MAX_ONES);
  assign inc_eff_s = inc_s & ~score_counter_clear & ~at_max_s;

  bcd_digit_counter u_ones (
    .clk      (score_counter_clk),
    .rst_n    (score_counter_rst_n),
    .clear    (score_counter_clear),
    .load     (1'b0),
    .load_val (4'd0),
    .inc      (inc_eff_s),
    .digit    (ones_s),
    .carry    (ones_carry_s)
  );

  // Tens never carries: the increment is gated off at 99.
  bcd_digit_counter u_tens (
    .clk      (score_counter_clk),
    .rst_n    (score_counter_rst_n),
    .clear    (score_counter_clear),
    .load     (1'b0),
    .load_val (4'd0),
    .inc      (ones_carry_s),
    .digit    (tens_s),
    .carry    (tens_carry_unused_s)
  );

  assign score_s     = {tens_s, ones_s};
  assign score_inc_s = bcd2_inc(score_s);

  // Score value the digit counters take at the coming edge.
  always_comb begin
    score_next_s = score_s;
    if (score_counter_clear) begin
      score_next_s = 8'h00;
    end else if (inc_eff_s) begin
      score_next_s = score_inc_s;
    end else begin
      score_next_s = score_s;
    end
  end

  // Saturation flag registered in step with the score digits.
  always_ff @(posedge score_counter_clk or negedge score_counter_rst_n) begin
    if (!score_counter_rst_n) begin
      max_r <= 1'b0;
    end else begin
      max_r <= (score_next_s == {SCORE_MAX_TENS, SCORE_MAX_ONES});
    end
  end

`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  logic high_load_s;
  logic high_ones_carry_unused_s;
  logic high_tens_carry_unused_s;

  // Score only rises by increments, so a new high can only appear on one.
  // BCD pairs compare correctly as plain unsigned bytes.
  assign high_load_s = inc_eff_s & (score_inc_s > {high_tens_s, high_ones_s});

  bcd_digit_counter u_high_ones (
    .clk      (score_counter_clk),
    .rst_n    (score_counter_rst_n),
    .clear    (1'b0),
    .load     (high_load_s),
    .load_val (score_inc_s[BCD_W-1:0]),
    .inc      (1'b0),
    .digit    (high_ones_s),
    .carry    (high_ones_carry_unused_s)
  );

  bcd_digit_counter u_high_tens (
    .clk      (score_counter_clk),
    .rst_n    (score_counter_rst_n),
    .clear    (1'b0),
    .load     (high_load_s),
    .load_val (score_inc_s[2*BCD_W-1:BCD_W]),
    .inc      (1'b0),
    .digit    (high_tens_s),
    .carry    (high_tens_carry_unused_s)
  );
`else
  assign high_ones_s = 4'd0;
  assign high_tens_s = 4'd0;
`endif

  // Scan prescaler: 0..SCAN_DIV-1, wrapping.
  always_ff @(posedge score_counter_clk or negedge score_counter_rst_n) begin
    if (!score_counter_rst_n) begin
      presc_r <= '0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  assign slot_tc_s = (presc_r == PRESC_LAST);

  // Slot that the next terminal count moves to.
  always_comb begin
    next_slot_s = slot_r;
    if (slot_r == LAST_SLOT) begin
      next_slot_s = SLOT_ONES;
    end else begin
      next_slot_s = slot_e'(slot_r + 2'd1);
    end
  end

  // Digit value for the incoming slot, sampled once at slot entry.
  always_comb begin
    digit_sel_s = 4'd0;
    case (next_slot_s)
      SLOT_ONES:      digit_sel_s = ones_s;
      SLOT_TENS:      digit_sel_s = tens_s;
      SLOT_HIGH_ONES: digit_sel_s = high_ones_s;
      SLOT_HIGH_TENS: digit_sel_s = high_tens_s;
      default:        digit_sel_s = 4'd0;
    endcase
  end

  // Slot, digit and anode load on the same edge so they never disagree.
  always_ff @(posedge score_counter_clk or negedge score_counter_rst_n) begin
    if (!score_counter_rst_n) begin
      slot_r  <= SLOT_ONES;
      digit_r <= 4'd0;
      anode_r <= ANODE_SLOT0;
    end else if (slot_tc_s) begin
      slot_r  <= next_slot_s;
      digit_r <= digit_sel_s;
      anode_r <= slot_anode(next_slot_s);
    end else begin
      slot_r  <= slot_r;
      digit_r <= digit_r;
      anode_r <= anode_r;
    end
  end

  assign score_counter_ones  = ones_s;
  assign score_counter_tens  = tens_s;
  assign score_counter_max   = max_r;
  assign score_counter_digit = digit_r;
  assign score_counter_anode = anode_r;

endmodule

// File: tb/tb_score_counter.sv
// ---------------------------------------------------------------------------
// tb_score_counter
// Self-checking bench for score_counter (SCAN_DIV = 4). A behavioural model
// tracks the score as an integer, the high score as a running maximum, and
// the scan position from the count of clock edges since reset.
// ---------------------------------------------------------------------------
module tb_score_counter;

  localparam int SCAN_DIV = 4;
`ifdef SCORE_COUNTER_HIGH_SCORE_EN
  localparam int NSLOTS = 4;
`else
  localparam int NSLOTS = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       eat;
  logic       clear;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       max_o;
  logic [3:0] digit;
  logic [7:0] anode;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_score;
  int m_high;
  int m_edges;
  bit m_eat_prev;
  int m_slot;
  int m_shown;

  typedef struct {
    logic       eat;
    logic       clear;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       max;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  score_counter #(.SCAN_DIV(SCAN_DIV)) dut (
    .score_counter_clk   (clk),
    .score_counter_rst_n (rst_n),
    .score_counter_eat   (eat),
    .score_counter_clear (clear),
    .score_counter_ones  (ones),
    .score_counter_tens  (tens),
    .score_counter_max   (max_o),
    .score_counter_digit (digit),
    .score_counter_anode (anode)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score    = 0;
    m_high     = 0;
    m_edges    = 0;
    m_eat_prev = 1'b0;
    m_slot     = 0;
    m_shown    = 0;
  endtask

  // One clock edge of the specification's behaviour, inputs as applied.
  task automatic model_step();
    int old_score;
    int old_high;
    old_score = m_score;
    old_high  = m_high;
    m_edges++;
    if (m_edges % SCAN_DIV == 0) begin
      m_slot = (m_edges / SCAN_DIV) % NSLOTS;
      case (m_slot)
        0:       m_shown = old_score % 10;
        1:       m_shown = old_score / 10;
        2:       m_shown = old_high % 10;
        default: m_shown = old_high / 10;
      endcase
    end
    if (clear) m_score = 0;
    else if (eat && !m_eat_prev && m_score < 99) m_score++;
    if (m_score > m_high) m_high = m_score;
    m_eat_prev = eat;
  endtask

  task automatic check_model();
    logic [7:0] exp_anode;
    exp_anode = 8'h01;
    exp_anode = ~(exp_anode << m_slot);
    check8("ones",  {4'h0, ones},  8'(m_score % 10));
    check8("tens",  {4'h0, tens},  8'(m_score / 10));
    check8("max",   {7'h0, max_o}, {7'h0, (m_score == 99)});
    check8("digit", {4'h0, digit}, 8'(m_shown));
    check8("anode", anode, exp_anode);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_model();
  endtask

  task automatic pulse();
    eat = 1'b1;
    tick();
    eat = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check8({tag, "_ones"},  {4'h0, ones},  8'h00);
    check8({tag, "_tens"},  {4'h0, tens},  8'h00);
    check8({tag, "_max"},   {7'h0, max_o}, 8'h00);
    check8({tag, "_digit"}, {4'h0, digit}, 8'h00);
    check8({tag, "_anode"}, anode,         8'hFE);
  endtask

  task automatic do_reset();
    eat   = 1'b0;
    clear = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check_reset_values("reset");
  endtask

  // Tick until the anode shows pat; an expired budget is a failure.
  task automatic wait_anode(input logic [7:0] pat);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      tick();
      if (anode == pat) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL wait_anode: anode %0h never reached %0h", anode, pat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    eat   = 1'b0;
    clear = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 4'd1, 4'd0, 1'b0};  // first edge
    tbl[1]  = '{1'b1, 1'b0, 4'd1, 4'd0, 1'b0};  // held high: no recount
    tbl[2]  = '{1'b0, 1'b0, 4'd1, 4'd0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'd2, 4'd0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 4'd2, 4'd0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b0};  // edge with clear is lost
    tbl[6]  = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b0};  // still high, no new edge
    tbl[7]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 4'd1, 4'd0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b0};  // clear held suppresses counting
    tbl[11] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0};

    // Scan timing after reset
    do_reset();
    repeat (SCAN_DIV - 1) tick();
    check8("scan_still_slot0", anode, 8'hFE);
    tick();
    check8("scan_slot1", anode, 8'hFD);
    repeat (SCAN_DIV * (NSLOTS - 1)) tick();
    check8("scan_wrap_slot0", anode, 8'hFE);

    // Table vectors
    do_reset();
    for (int i = 0; i < 12; i++) begin
      eat   = tbl[i].eat;
      clear = tbl[i].clear;
      tick();
      check8($sformatf("tbl%0d_ones", i), {4'h0, ones},  {4'h0, tbl[i].ones});
      check8($sformatf("tbl%0d_tens", i), {4'h0, tens},  {4'h0, tbl[i].tens});
      check8($sformatf("tbl%0d_max", i),  {7'h0, max_o}, {7'h0, tbl[i].max});
    end
    clear = 1'b0;

    // Held eat then 11 pulses -> 12
    do_reset();
    eat = 1'b1;
    repeat (20) tick();
    eat = 1'b0;
    tick();
    repeat (11) pulse();
    check8("hold_ones", {4'h0, ones}, 8'd2);
    check8("hold_tens", {4'h0, tens}, 8'd1);

    // Saturation
    do_reset();
    repeat (105) pulse();
    check8("sat_ones", {4'h0, ones},  8'd9);
    check8("sat_tens", {4'h0, tens},  8'd9);
    check8("sat_max",  {7'h0, max_o}, 8'd1);
    repeat (3) pulse();
    check8("sat2_ones", {4'h0, ones},  8'd9);
    check8("sat2_tens", {4'h0, tens},  8'd9);
    check8("sat2_max",  {7'h0, max_o}, 8'd1);

    // Clear coincident with an eat edge at 37
    do_reset();
    repeat (37) pulse();
    check8("pre_clr_ones", {4'h0, ones}, 8'd7);
    check8("pre_clr_tens", {4'h0, tens}, 8'd3);
    eat   = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check8("clr_ones", {4'h0, ones}, 8'd0);
    check8("clr_tens", {4'h0, tens}, 8'd0);
    eat = 1'b0;
    tick();
    eat = 1'b1;
    tick();
    check8("post_clr_ones", {4'h0, ones}, 8'd1);
    check8("post_clr_tens", {4'h0, tens}, 8'd0);
    eat = 1'b0;
    tick();

`ifdef SCORE_COUNTER_HIGH_SCORE_EN
    // High score survives clear
    do_reset();
    repeat (42) pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (15) pulse();
    wait_anode(8'hFB);
    check8("high_ones_42", {4'h0, digit}, 8'd2);
    wait_anode(8'hF7);
    check8("high_tens_42", {4'h0, digit}, 8'd4);
    repeat (28) pulse();
    wait_anode(8'hFB);
    check8("high_ones_43", {4'h0, digit}, 8'd3);
    wait_anode(8'hF7);
    check8("high_tens_43", {4'h0, digit}, 8'd4);
`endif

    // Asynchronous reset mid slot 1 at score 56
    do_reset();
    repeat (56) pulse();
    wait_anode(8'hFD);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    do_reset();

    // Random stimulus with occasional clears
    for (int i = 0; i < 1500; i++) begin
      eat   = 1'($urandom_range(0, 1));
      clear = ($urandom_range(0, 60) == 0);
      tick();
    end
    // Random stimulus without clears, long enough to saturate
    clear = 1'b0;
    for (int i = 0; i < 800; i++) begin
      eat = 1'($urandom_range(0, 1));
      tick();
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 300; i++) begin
      eat = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
